// File: rtl/w0rm_alu_pkg.sv
// W0RM ALU shared definitions: opcodes, unit indices, flag bit positions,
// dispatcher state encoding and the opcode-to-unit decode.
package w0rm_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_SEX = 4'ha;
  localparam logic [3:0] OP_ZEX = 4'hb;

  typedef logic [1:0] unit_idx_t;

  localparam unit_idx_t UNIT_ARITH  = 2'd0;
  localparam unit_idx_t UNIT_LOGIC  = 2'd1;
  localparam unit_idx_t UNIT_SHIFT  = 2'd2;
  localparam unit_idx_t UNIT_EXTEND = 2'd3;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_OVER  = 2;
  localparam int unsigned FLAG_CARRY = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic      legal;
    unit_idx_t unit;
  } alu_dec_t;

  // Opcodes are grouped in contiguous ranges per unit; 0xc-0xf are unassigned.
  function automatic alu_dec_t alu_decode(input logic [3:0] opcode);
    alu_dec_t dec;
    dec.legal = 1'b1;
    dec.unit  = UNIT_ARITH;
    if (opcode <= OP_SBC) begin
      dec.unit = UNIT_ARITH;
    end else if (opcode <= OP_NOT) begin
      dec.unit = UNIT_LOGIC;
    end else if (opcode <= OP_SHR) begin
      dec.unit = UNIT_SHIFT;
    end else if (opcode <= OP_ZEX) begin
      dec.unit = UNIT_EXTEND;
    end else begin
      dec.legal = 1'b0;
    end
    return dec;
  endfunction

endpackage

// File: rtl/w0rm_alu_unit_mux.sv
// Combinational selection of one sub-unit's result, valid and flags by unit index.
module w0rm_alu_unit_mux
  import w0rm_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_UNITS  = 4
) (
  input  unit_idx_t                       sel,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS-1:0]            unit_result_valid,
  input  logic [NUM_UNITS*4-1:0]          unit_result_flags,
  output logic [DATA_WIDTH-1:0]           sel_result,
  output logic                            sel_valid,
  output logic [3:0]                      sel_flags
);

  always_comb begin
    sel_result = '0;
    sel_valid  = 1'b0;
    sel_flags  = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      if (sel == unit_idx_t'(k)) begin
        sel_result = unit_result[k*DATA_WIDTH +: DATA_WIDTH];
        sel_valid  = unit_result_valid[k];
        sel_flags  = unit_result_flags[k*4 +: 4];
      end
    end
  end

endmodule

// File: rtl/w0rm_alu_dispatch.sv
// W0RM ALU front-end: accepts one op, issues it to a sub-unit, captures the reply
// and offers it to writeback. Define W0RM_ALU_DISPATCH_TIMEOUT_EN for the WAIT timeout.
module w0rm_alu_dispatch
  import w0rm_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            op_valid,
  output logic                            op_ready,
  input  logic [3:0]                      op_opcode,
  input  logic                            op_ext_8_16,
  input  logic [DATA_WIDTH-1:0]           op_data_a,
  input  logic [DATA_WIDTH-1:0]           op_data_b,
  output logic [NUM_UNITS-1:0]            unit_data_valid,
  output logic [3:0]                      unit_opcode,
  output logic                            unit_ext_8_16,
  output logic [DATA_WIDTH-1:0]           unit_data_a,
  output logic [DATA_WIDTH-1:0]           unit_data_b,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS-1:0]            unit_result_valid,
  input  logic [NUM_UNITS*4-1:0]          unit_result_flags,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [DATA_WIDTH-1:0]           wb_result,
  output logic [3:0]                      wb_flags,
  output logic                            wb_error,
  output logic [3:0]                      status_flags
);

  if (NUM_UNITS != 4) begin : g_bad_units
    $error("w0rm_alu_dispatch supports exactly four sub-units");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("w0rm_alu_dispatch needs TIMEOUT_CYCLES of at least 2");
  end

  state_t                  state_q, state_d;
  unit_idx_t               unit_sel_q, unit_sel_d;
  logic [NUM_UNITS-1:0]    unit_data_valid_q, unit_data_valid_d;
  logic [3:0]              unit_opcode_q, unit_opcode_d;
  logic                    unit_ext_q, unit_ext_d;
  logic [DATA_WIDTH-1:0]   unit_a_q, unit_a_d;
  logic [DATA_WIDTH-1:0]   unit_b_q, unit_b_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0]   wb_result_q, wb_result_d;
  logic [3:0]              wb_flags_q, wb_flags_d;
  logic                    wb_error_q, wb_error_d;
  logic [3:0]              status_q, status_d;

  alu_dec_t                dec;
  logic [DATA_WIDTH-1:0]   sel_result;
  logic                    sel_valid;
  logic [3:0]              sel_flags;

`ifdef W0RM_ALU_DISPATCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  w0rm_alu_unit_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_UNITS  (NUM_UNITS)
  ) u_unit_mux (
    .sel               (unit_sel_q),
    .unit_result       (unit_result),
    .unit_result_valid (unit_result_valid),
    .unit_result_flags (unit_result_flags),
    .sel_result        (sel_result),
    .sel_valid         (sel_valid),
    .sel_flags         (sel_flags)
  );

  always_comb begin
    state_d           = state_q;
    unit_sel_d        = unit_sel_q;
    unit_data_valid_d = '0;
    unit_opcode_d     = unit_opcode_q;
    unit_ext_d        = unit_ext_q;
    unit_a_d          = unit_a_q;
    unit_b_d          = unit_b_q;
    wb_valid_d        = wb_valid_q;
    wb_result_d       = wb_result_q;
    wb_flags_d        = wb_flags_q;
    wb_error_d        = wb_error_q;
    status_d          = status_q;
    dec               = alu_decode(op_opcode);
`ifdef W0RM_ALU_DISPATCH_TIMEOUT_EN
    cnt_d             = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          unit_opcode_d = op_opcode;
          unit_ext_d    = op_ext_8_16;
          unit_a_d      = op_data_a;
          unit_b_d      = op_data_b;
          if (dec.legal) begin
            unit_sel_d                   = dec.unit;
            unit_data_valid_d[dec.unit]  = 1'b1;
            state_d                      = ST_ISSUE;
          end else begin
            wb_valid_d  = 1'b1;
            wb_error_d  = 1'b1;
            wb_result_d = '0;
            wb_flags_d  = '0;
            state_d     = ST_DONE;
          end
        end
      end

      ST_ISSUE, ST_WAIT: begin
        if (sel_valid) begin
          wb_valid_d  = 1'b1;
          wb_error_d  = 1'b0;
          wb_result_d = sel_result;
          wb_flags_d  = sel_flags;
          status_d    = sel_flags;
          state_d     = ST_DONE;
        end else if (state_q == ST_ISSUE) begin
          state_d = ST_WAIT;
`ifdef W0RM_ALU_DISPATCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
`ifdef W0RM_ALU_DISPATCH_TIMEOUT_EN
          // A reply seen on the final count is taken above, so it beats the abort.
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            wb_valid_d  = 1'b1;
            wb_error_d  = 1'b1;
            wb_result_d = '0;
            wb_flags_d  = '0;
            state_d     = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end

      ST_DONE: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      unit_sel_q        <= UNIT_ARITH;
      unit_data_valid_q <= '0;
      unit_opcode_q     <= '0;
      unit_ext_q        <= 1'b0;
      unit_a_q          <= '0;
      unit_b_q          <= '0;
      wb_valid_q        <= 1'b0;
      wb_result_q       <= '0;
      wb_flags_q        <= '0;
      wb_error_q        <= 1'b0;
      status_q          <= '0;
    end else begin
      state_q           <= state_d;
      unit_sel_q        <= unit_sel_d;
      unit_data_valid_q <= unit_data_valid_d;
      unit_opcode_q     <= unit_opcode_d;
      unit_ext_q        <= unit_ext_d;
      unit_a_q          <= unit_a_d;
      unit_b_q          <= unit_b_d;
      wb_valid_q        <= wb_valid_d;
      wb_result_q       <= wb_result_d;
      wb_flags_q        <= wb_flags_d;
      wb_error_q        <= wb_error_d;
      status_q          <= status_d;
    end
  end

`ifdef W0RM_ALU_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign op_ready        = (state_q == ST_IDLE);
  assign unit_data_valid = unit_data_valid_q;
  assign unit_opcode     = unit_opcode_q;
  assign unit_ext_8_16   = unit_ext_q;
  assign unit_data_a     = unit_a_q;
  assign unit_data_b     = unit_b_q;
  assign wb_valid        = wb_valid_q;
  assign wb_result       = wb_result_q;
  assign wb_flags        = wb_flags_q;
  assign wb_error        = wb_error_q;
  assign status_flags    = status_q;

endmodule
